// File: rtl/chip8_program_loader.sv
// Fills the CPU instruction memory from a length-prefixed byte stream, then releases the CPU.
// Optional trailing checksum byte when CHIP8_LOADER_CHECKSUM_EN is defined.
module chip8_program_loader #(
  parameter logic [11:0] LoadBase = 12'h200,
  parameter int unsigned MemSize  = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        restart_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        mem_we_o,
  output logic [11:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_run_o
);

  localparam logic [16:0] MaxLen = 17'(MemSize - 32'(LoadBase));

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
`ifdef CHIP8_LOADER_CHECKSUM_EN
    StCksum,
`endif
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [11:0] len_q, len_d;
  logic [11:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q;
  logic        accept;
  logic        accepting;
  logic [16:0] len_full;
`ifdef CHIP8_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  cksum_res;
`endif

  // ready_q holds in_ready low until the first edge after reset release.
  always_comb begin
    accepting = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StData: accepting = 1'b1;
`ifdef CHIP8_LOADER_CHECKSUM_EN
      StCksum:                  accepting = 1'b1;
`endif
      default:                  accepting = 1'b0;
    endcase
  end

  assign in_ready_o  = ready_q && accepting;
  assign accept      = in_valid_i && in_ready_o;
  assign len_full    = {1'b0, len_hi_q, in_data_i};
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign done_o      = (state_q == StDone);
  assign cpu_run_o   = (state_q == StDone);
  assign error_o     = (state_q == StError);
`ifdef CHIP8_LOADER_CHECKSUM_EN
  assign busy_o      = (state_q == StData) || (state_q == StCksum);
  assign cksum_res   = sum_q + in_data_i;
`else
  assign busy_o      = (state_q == StData);
`endif

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef CHIP8_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      StLenHi: begin
        if (accept) begin
          len_hi_d = in_data_i;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
`ifdef CHIP8_LOADER_CHECKSUM_EN
          sum_d = 8'h00;
`endif
          if (len_full > MaxLen) begin
            state_d = StError;
          end else if (len_full == 17'd0) begin
`ifdef CHIP8_LOADER_CHECKSUM_EN
            state_d = StCksum;
`else
            state_d = StDone;
`endif
          end else begin
            len_d   = len_full[11:0];
            idx_d   = 12'd0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = LoadBase + idx_q;
          wdata_d = in_data_i;
          idx_d   = idx_q + 12'd1;
`ifdef CHIP8_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data_i;
          if (idx_d == len_q) state_d = StCksum;
`else
          if (idx_d == len_q) state_d = StDone;
`endif
        end
      end
`ifdef CHIP8_LOADER_CHECKSUM_EN
      StCksum: begin
        if (accept) state_d = (cksum_res == 8'h00) ? StDone : StError;
      end
`endif
      default: ;
    endcase
    // Restart wins over a coincident byte; an already-registered strobe is unaffected.
    if (restart_i) begin
      state_d = StLenHi;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StLenHi;
      len_hi_q <= 8'h00;
      len_q    <= 12'd0;
      idx_q    <= 12'd0;
      we_q     <= 1'b0;
      addr_q   <= 12'd0;
      wdata_q  <= 8'h00;
      ready_q  <= 1'b0;
`ifdef CHIP8_LOADER_CHECKSUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= 1'b1;
`ifdef CHIP8_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_chip8_program_loader.sv
// Directed bench for chip8_program_loader; memory writes checked against a scoreboard queue.
module tb_chip8_program_loader;

  logic        clk_i      = 1'b0;
  logic        rst_ni     = 1'b0;
  logic        restart_i  = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i  = 8'h00;
  logic        in_ready_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        cpu_run_o;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          base;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  always #5 clk_i = ~clk_i;

  chip8_program_loader dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .restart_i  (restart_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .cpu_run_o  (cpu_run_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest expected write; a strobe with nothing queued gets X.
  always @(negedge clk_i) begin
    if (rst_ni && mem_we_o) begin
      wr_cnt++;
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 20'bx;
      check("write", 32'({mem_addr_o, mem_wdata_o}), 32'(mon_exp));
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data,
                           input logic [11:0] addr);
    int waited;
    in_valid_i = 1'b0;
    repeat (gap) cycle();
    in_valid_i = 1'b1;
    in_data_i  = b;
    if (is_data) exp_q.push_back({addr, b});
    waited = 0;
    while (!in_ready_o && waited < 20) begin
      cycle();
      waited++;
    end
    check("ready_wait", 32'(waited < 20), 32'd1);
    cycle();
    in_valid_i = 1'b0;
    check("we_latency", 32'(mem_we_o), 32'(is_data));
  endtask

  task automatic send_cksum(input logic [7:0] b);
`ifdef CHIP8_LOADER_CHECKSUM_EN
    send_byte(b, 0, 1'b0, 12'h000);
`else
    b = b;
`endif
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    cycle();
    restart_i = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic bsy,
                              input logic dn, input logic er, input logic run);
    check({tag, "_ready"}, 32'(in_ready_o), 32'(rdy));
    check({tag, "_busy"},  32'(busy_o),     32'(bsy));
    check({tag, "_done"},  32'(done_o),     32'(dn));
    check({tag, "_error"}, 32'(error_o),    32'(er));
    check({tag, "_run"},   32'(cpu_run_o),  32'(run));
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    cycle();
    cycle();
    rst_ni = 1'b1;
    check("rel_ready_low", 32'(in_ready_o), 32'd0);
    cycle();
    check("rel_ready_high", 32'(in_ready_o), 32'd1);

    // 1: back-to-back image
    base = wr_cnt;
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h04, 0, 1'b0, 12'h000);
    check("t1_busy", 32'(busy_o), 32'd1);
    send_byte(8'h11, 0, 1'b1, 12'h200);
    send_byte(8'h04, 0, 1'b1, 12'h201);
    send_byte(8'h21, 0, 1'b1, 12'h202);
    send_byte(8'h08, 0, 1'b1, 12'h203);
    send_cksum(8'hC2);
    check_status("t1_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    in_valid_i = 1'b1;
    in_data_i  = 8'h55;
    repeat (3) cycle();
    in_valid_i = 1'b0;
    cycle();
    check("t1_wr_count", 32'(wr_cnt - base), 32'd4);
    check_status("t1_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // 2: same image with random gaps
    pulse_restart();
    check_status("t2_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    base = wr_cnt;
    send_byte(8'h00, $urandom_range(0, 3), 1'b0, 12'h000);
    send_byte(8'h04, $urandom_range(0, 3), 1'b0, 12'h000);
    send_byte(8'h11, $urandom_range(0, 3), 1'b1, 12'h200);
    send_byte(8'h04, $urandom_range(0, 3), 1'b1, 12'h201);
    send_byte(8'h21, $urandom_range(0, 3), 1'b1, 12'h202);
    send_byte(8'h08, $urandom_range(0, 3), 1'b1, 12'h203);
    send_cksum(8'hC2);
    repeat (2) cycle();
    check("t2_wr_count", 32'(wr_cnt - base), 32'd4);
    check_status("t2_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // 3: oversize length, then empty image
    pulse_restart();
    base = wr_cnt;
    send_byte(8'h0E, 0, 1'b0, 12'h000);
    send_byte(8'h01, 0, 1'b0, 12'h000);
    check_status("t3_err", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = 8'h77;
    repeat (3) cycle();
    in_valid_i = 1'b0;
    check("t3_wr_count", 32'(wr_cnt - base), 32'd0);
    check_status("t3_err_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_restart();
    check_status("t3_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_cksum(8'h00);
    repeat (2) cycle();
    check_status("t3_empty", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_empty_wr", 32'(wr_cnt - base), 32'd0);

    // 4: restart coincident with the third data byte
    pulse_restart();
    base = wr_cnt;
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h04, 0, 1'b0, 12'h000);
    send_byte(8'hA1, 0, 1'b1, 12'h200);
    send_byte(8'hA2, 0, 1'b1, 12'h201);
    in_valid_i = 1'b1;
    in_data_i  = 8'hA3;
    restart_i  = 1'b1;
    cycle();
    restart_i  = 1'b0;
    in_valid_i = 1'b0;
    check("t4_dropped_we", 32'(mem_we_o), 32'd0);
    check_status("t4_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_wr_before", 32'(wr_cnt - base), 32'd2);
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h02, 0, 1'b0, 12'h000);
    send_byte(8'h63, 0, 1'b1, 12'h200);
    send_byte(8'h42, 0, 1'b1, 12'h201);
    send_cksum(8'h5B);
    repeat (2) cycle();
    check("t4_wr_count", 32'(wr_cnt - base), 32'd4);
    check_status("t4_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef CHIP8_LOADER_CHECKSUM_EN
    // 5: bad checksum
    pulse_restart();
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h02, 0, 1'b0, 12'h000);
    send_byte(8'h63, 0, 1'b1, 12'h200);
    send_byte(8'h42, 0, 1'b1, 12'h201);
    check("t5_busy_cksum", 32'(busy_o), 32'd1);
    send_cksum(8'h5C);
    check_status("t5_bad", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // 6: asynchronous reset during DATA
    pulse_restart();
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h04, 0, 1'b0, 12'h000);
    send_byte(8'h11, 0, 1'b1, 12'h200);
    send_byte(8'h04, 0, 1'b1, 12'h201);
    #2;
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("t6_we", 32'(mem_we_o), 32'd0);
    check_status("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    rst_ni = 1'b1;
    check("t6_rel_ready_low", 32'(in_ready_o), 32'd0);
    cycle();
    check_status("t6_fresh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    base = wr_cnt;
    send_byte(8'h00, 0, 1'b0, 12'h000);
    send_byte(8'h01, 0, 1'b0, 12'h000);
    send_byte(8'hAA, 0, 1'b1, 12'h200);
    send_cksum(8'h56);
    repeat (2) cycle();
    check("t6_wr_count", 32'(wr_cnt - base), 32'd1);
    check_status("t6_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_program_loader.md
Name: chip8_program_loader

Overview:
Writer side of the CPU instruction memory. The CPU fetches big-endian 16-bit instructions byte-wise from its 4 KiB memory; this block fills that memory from a byte stream (host/UART link) and then releases the CPU. It accepts a length-prefixed image, writes it starting at LOAD_BASE, and asserts cpu_run when the image is complete.

Parameters:
LOAD_BASE, 12'h200, first memory address written; the CPU program entry point.
MEM_SIZE, 4096, memory size in bytes; the image must fit in [LOAD_BASE, MEM_SIZE).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
restart  input  1  single-cycle pulse; abort and await a new image
in_valid  input  1  in_data holds a byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts the byte this cycle
mem_we  output  1  memory write strobe, one cycle per byte
mem_addr  output  12  write address
mem_wdata  output  8  write data
busy  output  1  image transfer in progress (length received, not finished)
done  output  1  image loaded successfully
error  output  1  sticky load failure
cpu_run  output  1  CPU enable; low holds the CPU idle

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low on rst_n.
- Reset: every output is 0, including in_ready. State is LEN_HI. in_ready rises on the first clock edge after rst_n deasserts.
- Transfer: a byte is accepted on a rising edge when in_valid && in_ready. in_valid may drop or gap at any time, and back-to-back bytes are accepted every cycle.
- States and transitions:
  - LEN_HI: accept the length high byte, then go to LEN_LO.
  - LEN_LO: accept the low byte; L = {hi, lo}.
    - If L > MEM_SIZE-LOAD_BASE (3584 at defaults), go to ERROR.
    - Otherwise, if L == 0, go to CKSUM (macro built) or DONE.
    - Otherwise, clear the 12-bit index and go to DATA.
  - DATA: for each accepted byte, exactly one cycle later: mem_we=1, mem_addr=LOAD_BASE+index, mem_wdata=byte. The index then increments.
    - When the L-th byte is accepted, go to CKSUM or DONE.
    - DONE/done is entered on the same edge the last byte is accepted; its write strobe appears in the following cycle.
  - DONE: in_ready=0, done=1, cpu_run=1 (registered). Extra in_valid is ignored.
  - ERROR: in_ready=0, error=1, cpu_run=0, and no further writes.
- busy=1 in DATA and CKSUM only.
- mem_we is never asserted outside a DATA acceptance.
- Address arithmetic is 12-bit. It cannot wrap, because of the length check.
- restart: from any state, the next state is LEN_HI and done/error/cpu_run clear on that edge.
  - restart takes priority over a simultaneous byte acceptance; that byte is dropped.
  - A write strobe already scheduled from the previous cycle still issues.
- rst_n asserted mid-operation: outputs clear immediately (asynchronously). A pending write is discarded.

Optional Feature:
CHIP8_LOADER_CHECKSUM_EN.
- Defined:
  - The image is followed by one checksum byte, accepted in state CKSUM.
  - An 8-bit running sum (mod 256) covers the data bytes only.
  - If (sum + checksum byte) mod 256 == 0, go to DONE; otherwise go to ERROR.
  - L == 0 still requires a checksum byte, which must be 00.
- Undefined: there is no CKSUM state and no checksum byte, and the stream ends after L data bytes.

Test Plan:
1. Stream 00 04 11 04 21 08 (no checksum) -> writes 200=11, 201=04, 202=21, 203=08, each one cycle after its acceptance. Then done=1, cpu_run=1, in_ready=0, error=0.
2. Same image with in_valid gaps of 0-3 random cycles between bytes -> identical write sequence, exactly 4 mem_we pulses.
3. Length 0E 01 -> error=1, in_ready=0 after the LEN_LO edge, zero mem_we pulses, cpu_run stays 0. A restart pulse followed by stream 00 00 -> done=1 with no writes.
4. Restart pulse after 2 of 4 data bytes, coincident with the 3rd byte -> 3rd byte dropped, no 3rd write. Then stream 00 02 63 42 -> writes 200=63, 201=42, done=1.
5. Checksum build: 00 02 63 42 5B -> done=1 (63+42+5B = 0x100). With 5C as the final byte -> error=1, cpu_run=0.
6. rst_n driven low in the middle of DATA -> mem_we, in_ready, busy, done and cpu_run read 0 before the next clock edge. After release the loader accepts a fresh length at LEN_HI.
